// File: rtl/mipi_dphy_pkg.sv
// Shared definitions for the D-PHY transmit path: HS state encoding and the default leader byte.
package mipi_dphy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } hs_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/hs_serializer.sv
// HS burst serializer: leader byte, payload bytes and HS-trail, emitted as 2-bit pairs
// (even bit on Serial_B1, odd bit on Serial_B2) for a downstream DDR output register.
module hs_serializer
    import mipi_dphy_pkg::*;
#(
    parameter int unsigned TRAIL_CYCLES = 8,
    parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic       TX_DDR_clk,
    input  logic       TX_rst_n,
    input  logic       HS_req,
    input  logic [7:0] Byte_data,
    input  logic       Byte_valid,
    output logic       Byte_ready,
    output logic       Serial_B1,
    output logic       Serial_B2,
    output logic       Enable,
    output logic       HS_busy
);

    localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYCLES);

    hs_state_t   state;
    logic [1:0]  phase;
    logic [7:0]  trail_cnt;
    logic [5:0]  rest;       // untransmitted bits of the current byte, LSB pair next
    logic        handshake;

    // Ready only in the last pair slot so the next byte follows with no gap.
    assign Byte_ready = ((state == SYNC) || (state == DATA)) && (phase == 2'd3) && HS_req;
    assign handshake  = Byte_ready && Byte_valid;

    always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
        if (!TX_rst_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            trail_cnt <= 8'd0;
            rest      <= 6'd0;
            Serial_B1 <= 1'b0;
            Serial_B2 <= 1'b0;
            Enable    <= 1'b0;
            HS_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (HS_req && Byte_valid) begin
                        state                  <= SYNC;
                        phase                  <= 2'd0;
                        {Serial_B2, Serial_B1} <= SYNC_BYTE[1:0];
                        rest                   <= SYNC_BYTE[7:2];
                        Enable                 <= 1'b1;
                        HS_busy                <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (phase != 2'd3) begin
                        phase                  <= phase + 2'd1;
                        {Serial_B2, Serial_B1} <= rest[1:0];
                        rest                   <= {2'b00, rest[5:2]};
                    end else if (handshake) begin
                        state                  <= DATA;
                        phase                  <= 2'd0;
                        {Serial_B2, Serial_B1} <= Byte_data[1:0];
                        rest                   <= Byte_data[7:2];
                    end else begin
                        // Trail level is the inverse of the last bit sent (the odd bit).
                        state     <= TRAIL;
                        phase     <= 2'd0;
                        trail_cnt <= 8'd1;
                        Serial_B1 <= ~Serial_B2;
                        Serial_B2 <= ~Serial_B2;
                    end
                end
                TRAIL: begin
                    if (trail_cnt == TRAIL_LAST) begin
                        state     <= IDLE;
                        trail_cnt <= 8'd0;
                        Serial_B1 <= 1'b0;
                        Serial_B2 <= 1'b0;
                        Enable    <= 1'b0;
                        HS_busy   <= 1'b0;
                    end else begin
                        trail_cnt <= trail_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_serializer.sv
// Directed bench for hs_serializer: sync/data pairs, back-to-back bytes, empty burst,
// early HS_req drop, reset mid-burst and a one-cycle trail variant.
module tb_hs_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, valid;
    logic [7:0] data;
    logic       ready, b1, b2, en, busy;

    logic       req2, valid2;
    logic [7:0] data2;
    logic       ready2, b1_2, b2_2, en2, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hs_serializer dut (
        .TX_DDR_clk(clk), .TX_rst_n(rst_n), .HS_req(req), .Byte_data(data),
        .Byte_valid(valid), .Byte_ready(ready), .Serial_B1(b1), .Serial_B2(b2),
        .Enable(en), .HS_busy(busy)
    );

    hs_serializer #(.TRAIL_CYCLES(1)) dut_t1 (
        .TX_DDR_clk(clk), .TX_rst_n(rst_n), .HS_req(req2), .Byte_data(data2),
        .Byte_valid(valid2), .Byte_ready(ready2), .Serial_B1(b1_2), .Serial_B2(b2_2),
        .Enable(en2), .HS_busy(busy2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four pair slots of one byte; inputs for the following handshake are set after slot 0.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic nxt_req,
                             input logic nxt_valid, input logic [7:0] nxt_data);
        logic [7:0] bv;
        bv = b;
        for (int p = 0; p < 4; p++) begin
            tick();
            chk({tag, "_pair"}, {6'd0, b2, b1}, {6'd0, bv[2*p+1], bv[2*p]});
            chk({tag, "_en"}, {7'd0, en}, 8'd1);
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_ready"}, {7'd0, ready}, {7'd0, (p == 3) && req});
            if (p == 0) begin
                req   = nxt_req;
                valid = nxt_valid;
                data  = nxt_data;
            end
        end
    endtask

    task automatic trail(input string tag, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_trail"}, {6'd0, b2, b1}, {6'd0, v, v});
            chk({tag, "_trail_en"}, {7'd0, en}, 8'd1);
            chk({tag, "_trail_rdy"}, {7'd0, ready}, 8'd0);
            if (i == 0) begin
                req   = 1'b0;
                valid = 1'b0;
            end
        end
        tick();
        chk({tag, "_idle_pair"}, {6'd0, b2, b1}, 8'd0);
        chk({tag, "_idle_en"}, {7'd0, en}, 8'd0);
        chk({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; valid = 1'b0; data = 8'h00;
        req2 = 1'b0; valid2 = 1'b0; data2 = 8'h00;
        #2;
        chk("rst_pair", {6'd0, b2, b1}, 8'd0);
        chk("rst_en", {7'd0, en}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Sync sequence with one payload byte 0xA5
        req = 1'b1; valid = 1'b1; data = 8'hA5;
        #1 chk("idle_ready", {7'd0, ready}, 8'd0);
        send_byte("s1_sync", 8'hB8, 1'b1, 1'b1, 8'hA5);
        send_byte("s1_a5", 8'hA5, 1'b1, 1'b0, 8'hA5);
        trail("s1", 1'b0, 8);

        // Back-to-back 0x00, 0xFF, 0x3C
        req = 1'b1; valid = 1'b1; data = 8'h00;
        send_byte("b2b_sync", 8'hB8, 1'b1, 1'b1, 8'h00);
        send_byte("b2b_00", 8'h00, 1'b1, 1'b1, 8'hFF);
        send_byte("b2b_ff", 8'hFF, 1'b1, 1'b1, 8'h3C);
        send_byte("b2b_3c", 8'h3C, 1'b1, 1'b0, 8'h3C);
        trail("b2b", 1'b1, 8);

        // Empty burst: sync only
        req = 1'b1; valid = 1'b1; data = 8'h55;
        send_byte("empty_sync", 8'hB8, 1'b0, 1'b0, 8'h55);
        trail("empty", 1'b0, 8);

        // HS_req drops during byte 0x81; byte still completes
        req = 1'b1; valid = 1'b1; data = 8'h81;
        send_byte("drop_sync", 8'hB8, 1'b1, 1'b1, 8'h81);
        send_byte("drop_81", 8'h81, 1'b0, 1'b0, 8'h00);
        trail("drop", 1'b0, 8);

        // Reset asserted at phase 2 of a data byte
        req = 1'b1; valid = 1'b1; data = 8'hA5;
        send_byte("rm_sync", 8'hB8, 1'b1, 1'b1, 8'hA5);
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("rm_ph2_pair", {6'd0, b2, b1}, 8'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_async_pair", {6'd0, b2, b1}, 8'd0);
        chk("rm_async_en", {7'd0, en}, 8'd0);
        chk("rm_async_busy", {7'd0, busy}, 8'd0);
        chk("rm_async_ready", {7'd0, ready}, 8'd0);
        tick();
        chk("rm_hold_en", {7'd0, en}, 8'd0);
        rst_n = 1'b1; req = 1'b1; valid = 1'b1; data = 8'hA5;
        send_byte("rm_resync", 8'hB8, 1'b1, 1'b1, 8'hA5);
        send_byte("rm_a5", 8'hA5, 1'b1, 1'b0, 8'hA5);
        trail("rm", 1'b0, 8);

        // TRAIL_CYCLES=1 instance, HS_req held high throughout
        req2 = 1'b1; valid2 = 1'b1; data2 = 8'h00;
        tick();
        chk("t1_sync_pair", {6'd0, b2_2, b1_2}, 8'b00);
        chk("t1_sync_en", {7'd0, en2}, 8'd1);
        valid2 = 1'b0;
        tick();
        tick();
        tick();
        chk("t1_ph3_ready", {7'd0, ready2}, 8'd1);
        tick();
        chk("t1_trail_pair", {6'd0, b2_2, b1_2}, 8'b00);
        chk("t1_trail_en", {7'd0, en2}, 8'd1);
        chk("t1_trail_busy", {7'd0, busy2}, 8'd1);
        valid2 = 1'b1;
        tick();
        chk("t1_idle_en", {7'd0, en2}, 8'd0);
        chk("t1_idle_busy", {7'd0, busy2}, 8'd0);
        tick();
        chk("t1_resync_en", {7'd0, en2}, 8'd1);
        chk("t1_resync_busy", {7'd0, busy2}, 8'd1);
        chk("t1_resync_pair", {6'd0, b2_2, b1_2}, 8'b00);
        req2 = 1'b0; valid2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
